// File: rtl/latch_stim_gen.sv
// latch_stim_gen: stimulus stage for a D-latch / posedge-FF / negedge-FF storage trio.
//
// A parallel Pattern is captured on Start (IDLE only) and serialised MSB-first on D.
// For every bit the sequence is SETUP (1 cycle), GATE_HI (EN_HIGH cycles), and
// GATE_LO (EN_LOW cycles). D is updated only on the edge that enters SETUP, so the
// gate pulse always has one full cycle of setup before it and EN_LOW cycles of hold
// after it.
//
// Optional build macro: GLITCH_INJECT_EN. When it is defined and EN_HIGH >= 2, D carries
// the inverted bit for the first GATE_HI cycle and the true bit after that. A transparent
// latch then shows a visible glitch, but its final held value is still correct.
//
// Ports:
//   Clk     in   rising-edge system clock
//   Rst     in   asynchronous active-high reset
//   Start   in   run request, sampled only in IDLE
//   Pattern in   [PATTERN_W] data to serialise, captured on the accepting edge
//   D       out  serial data
//   Gate    out  enable/clock pulse, one per bit
//   Busy    out  high from the accepting edge until DONE
//   Done    out  one-cycle completion pulse
//   BitIdx  out  [clog2(PATTERN_W)] index of the bit currently on D
//
// All outputs are registered.
module latch_stim_gen #(
  parameter int unsigned PATTERN_W = 8,
  parameter int unsigned EN_HIGH   = 2,
  parameter int unsigned EN_LOW    = 2
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Start,
  input  logic [PATTERN_W-1:0]         Pattern,
  output logic                         D,
  output logic                         Gate,
  output logic                         Busy,
  output logic                         Done,
  output logic [$clog2(PATTERN_W)-1:0] BitIdx
);

  localparam int unsigned IdxW  = $clog2(PATTERN_W);
  localparam int unsigned PhMax = (EN_HIGH > EN_LOW) ? EN_HIGH : EN_LOW;
  localparam int unsigned PhW   = $clog2(PhMax + 1);

  // The phase counter holds "cycles remaining minus one" and is reloaded on each state entry.
  localparam logic [PhW-1:0]  HiLoad = PhW'(EN_HIGH - 1);
  localparam logic [PhW-1:0]  LoLoad = PhW'(EN_LOW - 1);
  localparam logic [IdxW-1:0] IdxTop = IdxW'(PATTERN_W - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSetup  = 3'd1;
  localparam logic [2:0] StGateHi = 3'd2;
  localparam logic [2:0] StGateLo = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [PhW-1:0]       phase_q, phase_d;
  logic [PATTERN_W-1:0] shreg_q, shreg_d;
  logic                 d_q, d_d;
  logic                 gate_q, gate_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [IdxW-1:0]      idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    shreg_d = shreg_q;
    d_d     = d_q;
    gate_d  = gate_q;
    busy_d  = busy_q;
    done_d  = done_q;
    idx_d   = idx_q;

    case (state_q)
      StIdle: begin
        gate_d = 1'b0;
        if (Start) begin
          shreg_d = Pattern;
          d_d     = Pattern[PATTERN_W-1];
          idx_d   = IdxTop;
          busy_d  = 1'b1;
          phase_d = '0;
          state_d = StSetup;
        end
      end

      StSetup: begin
        gate_d  = 1'b1;
        phase_d = HiLoad;
        state_d = StGateHi;
`ifdef GLITCH_INJECT_EN
        // The inverted bit is driven for the first high cycle only.
        if (EN_HIGH >= 2) d_d = ~shreg_q[PATTERN_W-1];
`endif
      end

      StGateHi: begin
`ifdef GLITCH_INJECT_EN
        // Restore the true bit after the injected glitch cycle.
        d_d = shreg_q[PATTERN_W-1];
`endif
        if (phase_q == '0) begin
          gate_d  = 1'b0;
          phase_d = LoLoad;
          state_d = StGateLo;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      StGateLo: begin
        if (phase_q == '0) begin
          phase_d = '0;
          if (idx_q != '0) begin
            idx_d   = idx_q - 1'b1;
            shreg_d = shreg_q << 1;
            d_d     = shreg_q[PATTERN_W-2];
            state_d = StSetup;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      StDone: begin
        done_d  = 1'b0;
        gate_d  = 1'b0;
        phase_d = '0;
        state_d = StIdle;
      end

      default: begin
        gate_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        phase_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      shreg_q <= '0;
      d_q     <= 1'b0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      shreg_q <= shreg_d;
      d_q     <= d_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
    end
  end

  assign D      = d_q;
  assign Gate   = gate_q;
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign BitIdx = idx_q;

endmodule

// File: tb/tb_latch_stim_gen.sv
// Bench for latch_stim_gen. Instance 0 uses the default parameters (8/2/2) and
// instance 1 uses the sweep parameters (4/1/3). Both instances share Start and Rst.
// Instance 1 receives Pattern[3:0].
module tb_latch_stim_gen;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Start;
  logic [7:0] Pattern;

  logic       d0, g0, b0, dn0;
  logic [2:0] i0;
  logic       d1, g1, b1, dn1;
  logic [1:0] i1;

  always #5 Clk = ~Clk;

  latch_stim_gen #(.PATTERN_W(8), .EN_HIGH(2), .EN_LOW(2)) u_dut0 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Pattern(Pattern),
    .D(d0), .Gate(g0), .Busy(b0), .Done(dn0), .BitIdx(i0)
  );

  latch_stim_gen #(.PATTERN_W(4), .EN_HIGH(1), .EN_LOW(3)) u_dut1 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Pattern(Pattern[3:0]),
    .D(d1), .Gate(g1), .Busy(b1), .Done(dn1), .BitIdx(i1)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: each run is a timeline of W*P cycles plus one Done cycle.
  int          m_act[2];
  int          m_k[2];
  logic [31:0] m_pat[2];

  // Monitors.
  logic        gp[2], dp[2], bp[2];
  int          hl[2], pulses[2], busy_cnt[2], acc[2], lat[2], done_cyc[2];
  logic [31:0] cap[2];
  int          hold_viol = 0;
  int          width_bad = 0;

  function automatic int cw(input int j);  return (j == 0) ? 8 : 4; endfunction
  function automatic int ceh(input int j); return (j == 0) ? 2 : 1; endfunction
  function automatic int cel(input int j); return (j == 0) ? 2 : 3; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int j, input logic st, input logic [31:0] pat);
    int p;
    p = 1 + ceh(j) + cel(j);
    if (m_act[j] != 0) begin
      m_k[j]++;
      if (m_k[j] > cw(j) * p) m_act[j] = 0;
    end else if (st) begin
      m_act[j] = 1;
      m_k[j]   = 0;
      m_pat[j] = pat;
    end
  endtask

  task automatic model_exp(input int j, output logic d, output logic g, output logic b,
                           output logic dn, output int idx);
    int p, i, r;
    logic bit_v;
    p = 1 + ceh(j) + cel(j);
    d = m_pat[j][0];
    g = 1'b0; b = 1'b0; dn = 1'b0; idx = 0;
    if (m_act[j] != 0) begin
      if (m_k[j] == cw(j) * p) begin
        dn = 1'b1;
      end else begin
        i     = m_k[j] / p;
        r     = m_k[j] % p;
        bit_v = m_pat[j][cw(j) - 1 - i];
        d     = bit_v;
        g     = (r >= 1) && (r <= ceh(j));
        b     = 1'b1;
        idx   = cw(j) - 1 - i;
`ifdef GLITCH_INJECT_EN
        if (ceh(j) >= 2 && r == 1) d = ~bit_v;
`endif
      end
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_act[j] = 0; m_k[j] = 0; m_pat[j] = 0;
      gp[j] = 1'b0; dp[j] = 1'b0; bp[j] = 1'b0; hl[j] = 0;
    end
  endtask

  task automatic monitor(input int j, input logic d, input logic g, input logic b,
                         input logic dn);
    if (b && !bp[j]) acc[j] = cyc;
    if (b) busy_cnt[j]++;
    if (dn) begin
      lat[j]      = cyc - acc[j];
      done_cyc[j] = cyc;
    end
    if (g) hl[j]++;
    if (gp[j] && !g) begin
      cap[j] = (cap[j] << 1) | {31'b0, d};
      pulses[j]++;
      if (hl[j] != ceh(j)) width_bad++;
      hl[j] = 0;
    end
`ifndef GLITCH_INJECT_EN
    if ((g || gp[j]) && d !== dp[j]) hold_viol++;
`endif
    gp[j] = g; dp[j] = d; bp[j] = b;
  endtask

  task automatic compare_all();
    logic ed, eg, eb, edn;
    int   ei;
    model_exp(0, ed, eg, eb, edn, ei);
    chk("d0", d0, ed);   chk("gate0", g0, eg); chk("busy0", b0, eb);
    chk("done0", dn0, edn); chk("idx0", 32'(i0), ei);
    model_exp(1, ed, eg, eb, edn, ei);
    chk("d1", d1, ed);   chk("gate1", g1, eg); chk("busy1", b1, eb);
    chk("done1", dn1, edn); chk("idx1", 32'(i1), ei);
  endtask

  task automatic tick(input logic st, input logic [7:0] pat);
    Start   = st;
    Pattern = pat;
    @(posedge Clk);
    model_step(0, st, {24'b0, pat});
    model_step(1, st, {28'b0, pat[3:0]});
    #1;
    cyc++;
    compare_all();
    monitor(0, d0, g0, b0, dn0);
    monitor(1, d1, g1, b1, dn1);
  endtask

  task automatic clear_caps();
    for (int j = 0; j < 2; j++) begin
      cap[j] = 0; pulses[j] = 0; busy_cnt[j] = 0; lat[j] = -1;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) tick(1'b0, 8'h00);
  endtask

  typedef struct {
    logic [7:0] pat;
    logic [7:0] bits0;
    logic [3:0] bits1;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{pat: 8'hA5, bits0: 8'hA5, bits1: 4'h5};
    tbl[1] = '{pat: 8'h3C, bits0: 8'h3C, bits1: 4'hC};
    tbl[2] = '{pat: 8'h09, bits0: 8'h09, bits1: 4'h9};
    tbl[3] = '{pat: 8'h5A, bits0: 8'h5A, bits1: 4'hA};

    Rst = 1'b1; Start = 1'b0; Pattern = 8'h00;
    model_reset();
    clear_caps();
    #1;
    chk("rst_d0", d0, 1'b0); chk("rst_gate0", g0, 1'b0); chk("rst_busy0", b0, 1'b0);
    chk("rst_done0", dn0, 1'b0); chk("rst_idx0", 32'(i0), 0);
    @(posedge Clk); @(posedge Clk); #2;
    Rst = 1'b0;
    tick(1'b0, 8'h00);

    // Table: one run per entry. Start pulses at cycles 3 and 20 must be ignored.
    foreach (tbl[v]) begin
      clear_caps();
      tick(1'b1, tbl[v].pat);
      for (int n = 1; n < 60 && !dn0; n++) tick(n == 3 || n == 20, tbl[v].pat ^ 8'hFF);
      chk("tbl_done_seen", dn0, 1'b1);
      chk("tbl_bits0", cap[0], {24'b0, tbl[v].bits0});
      chk("tbl_pulses0", pulses[0], 8);
      chk("tbl_lat0", lat[0], 40);
      chk("tbl_busy0", busy_cnt[0], 40);
      chk("tbl_bits1", cap[1], {28'b0, tbl[v].bits1});
      chk("tbl_pulses1", pulses[1], 4);
      chk("tbl_lat1", lat[1], 20);
      chk("tbl_busy1", busy_cnt[1], 20);
      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
    end

    // Back-to-back FF then 00 with Start held high.
    clear_caps();
    tick(1'b1, 8'hFF);
    for (int n = 1; n < 60 && !dn0; n++) tick(1'b1, 8'hFF);
    chk("b2b_bits_ff", cap[0], 32'hFF);
    clear_caps();
    for (int n = 0; n < 5 && !b0; n++) tick(1'b1, 8'h00);
    chk("b2b_restart_gap", acc[0] - done_cyc[0], 2);
    for (int n = 0; n < 60 && !dn0; n++) tick(1'b0, 8'h00);
    chk("b2b_bits_00", cap[0], 32'h00);
    chk("b2b_pulses", pulses[0], 8);
    drain();

    // Random stimulus against the timeline model.
    for (int n = 0; n < 600; n++) tick(($urandom % 6) == 0, 8'($urandom));
    drain();

    // Asynchronous reset in the middle of GATE_HI for bit 5.
    tick(1'b1, 8'hA5);
    for (int n = 0; n < 11; n++) tick(1'b0, 8'h00);
    chk("pre_rst_gate", g0, 1'b1);
    chk("pre_rst_idx", 32'(i0), 5);
    #2;
    Rst = 1'b1;
    #1;
    chk("async_d0", d0, 1'b0); chk("async_gate0", g0, 1'b0); chk("async_busy0", b0, 1'b0);
    chk("async_done0", dn0, 1'b0); chk("async_idx0", 32'(i0), 0);
    chk("async_gate1", g1, 1'b0); chk("async_busy1", b1, 1'b0);
    model_reset();
    @(posedge Clk); #2;
    Rst = 1'b0;
    tick(1'b0, 8'h00);
    tick(1'b1, 8'h81);
    chk("restart_idx", 32'(i0), 7);
    chk("restart_d", d0, 1'b1);
    drain();

`ifndef GLITCH_INJECT_EN
    chk("hold_violations", hold_viol, 0);
`endif
    chk("gate_width", width_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
